// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/div sequencer owning the HI/LO pair, with mthi/mtlo, mfhi/mflo and pipeline stall.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  HiLoWr,
    input  logic [1:0]  REOp,
    input  logic [31:0] WD,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] RD,
    output logic        Busy,
    output logic        Stall
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic        last, accept, sgn, is_div;
    logic [63:0] sa, sb, prod_s, prod_u, msub_r, res;
    logic [31:0] dvd, dvs, uq, ur, quo, rem;
    always_comb begin
        last    = state_q == RUN && count_q == 4'd1;
        accept  = Start && MDOp <= 3'd4 && (state_q == IDLE || last);
        sa      = {{32{a_q[31]}}, a_q};
        sb      = {{32{b_q[31]}}, b_q};
        prod_s  = sa * sb;
        prod_u  = {32'd0, a_q} * {32'd0, b_q};
        msub_r  = {hi_q, lo_q} - prod_s;
        // One unsigned divider serves both div flavours; signed ops divide magnitudes and fix signs after
        sgn     = op_q == 3'd2;
        is_div  = op_q[2:1] == 2'b01;
        dvd     = sgn && a_q[31] ? -a_q : a_q;
        dvs     = sgn && b_q[31] ? -b_q : b_q;
        uq      = dvs == 32'd0 ? 32'd0 : dvd / dvs;
        ur      = dvs == 32'd0 ? 32'd0 : dvd % dvs;
        quo     = sgn && (a_q[31] ^ b_q[31]) ? -uq : uq;
        rem     = sgn && a_q[31] ? -ur : ur;
        res     = op_q == 3'd0 ? prod_s : op_q == 3'd1 ? prod_u : op_q == 3'd4 ? msub_r : {rem, quo};
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == RUN) begin
            count_d = count_q - 4'd1;
            if (last) begin
                state_d = IDLE;
                if (!(is_div && b_q == 32'd0))
                    {hi_d, lo_d} = res;
            end
        end else if (!accept) begin
            hi_d = HiLoWr == 2'b01 ? WD : hi_q;
            lo_d = HiLoWr == 2'b10 ? WD : lo_q;
        end
        if (accept) begin
            state_d = RUN;
            op_d    = MDOp;
            a_d     = A;
            b_d     = B;
            count_d = MDOp[2:1] == 2'b01 ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign Busy  = state_q == RUN;
    assign RD    = REOp == 2'b01 ? hi_q : REOp == 2'b10 ? lo_q : 32'd0;
    assign Stall = Busy && (Start || HiLoWr == 2'b01 || HiLoWr == 2'b10 || REOp == 2'b01 || REOp == 2'b10);
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed and random stimulus against a cycle-level HI/LO model, checked through a scoreboard queue.
module tb_md_sequencer;
    localparam int MC = 5;
    localparam int DC = 10;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  MDOp = '0;
    logic [31:0] A = '0, B = '0, WD = '0;
    logic [1:0]  HiLoWr = '0, REOp = '0;
    logic [31:0] HI, LO, RD;
    logic        Busy, Stall;
    md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .HiLoWr(HiLoWr), .REOp(REOp), .WD(WD), .HI(HI), .LO(LO), .RD(RD),
        .Busy(Busy), .Stall(Stall)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic        busy;
        logic        stall;
        logic [31:0] rd;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;
    logic        m_commit = 1'b0;
    int          m_left = 0;
    // Reference arithmetic is done in 64-bit integers so the result comes straight from the math
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        m_commit = 1'b1;
        m_left   = (op == 3'd2 || op == 3'd3) ? DC : MC;
        case (op)
            3'd0: m_res = sa * sb;
            3'd1: m_res = ua * ub;
            3'd4: m_res = {m_hi, m_lo} - 64'(sa * sb);
            3'd2: if (b == 0) m_commit = 1'b0; else m_res = {32'(sa % sb), 32'(sa / sb)};
            default: if (b == 0) m_commit = 1'b0; else m_res = {32'(ua % ub), 32'(ua / ub)};
        endcase
    endtask
    task automatic step(input logic r, input logic s, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] wr, input logic [1:0] re, input logic [31:0] wd);
        exp_t e;
        int   prev;
        @(negedge clk);
        rst_n = r; Start = s; MDOp = op; A = a; B = b; HiLoWr = wr; REOp = re; WD = wd;
        if (!r) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end
        e.busy  = m_left > 0;
        e.stall = e.busy && (s || wr == 2'b01 || wr == 2'b10 || re == 2'b01 || re == 2'b10);
        e.rd    = re == 2'b01 ? m_hi : re == 2'b10 ? m_lo : 32'd0;
        e.hi    = m_hi;
        e.lo    = m_lo;
        exp_q.push_back(e);
        if (r) begin
            prev = m_left;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0 && m_commit) {m_hi, m_lo} = m_res;
            end
            if (s && op <= 3'd4 && prev <= 1) issue(op, a, b);
            else if (prev == 0) begin
                if (wr == 2'b01) m_hi = wd;
                if (wr == 2'b10) m_lo = wd;
            end
        end
    endtask
    task automatic idle(input int n, input logic [1:0] re);
        repeat (n) step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 2'b00, re, 32'd0);
    endtask
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({Busy, Stall, RD, HI, LO} !== e) begin
                    miscompares++;
                    $display("FAIL outputs cyc %0d: busy %b want %b, stall %b want %b, rd %h want %h, hi %h want %h, lo %h want %h",
                             cyc, Busy, e.busy, Stall, e.stall, RD, e.rd, HI, e.hi, LO, e.lo);
                end
            end
        end
    end
    initial begin
        repeat (2) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 2'b00, 2'b01, 32'd0);
        step(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 2'b00, 2'b00, 32'd0);
        idle(MC, 2'b01);
        step(1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 2'b00, 2'b10, 32'd0);
        idle(MC + 1, 2'b10);
        step(1'b1, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00, 32'd0);
        step(1'b1, 1'b1, 3'd3, 32'd1, 32'd1, 2'b01, 2'b00, 32'hDEAD);
        idle(DC, 2'b01);
        step(1'b1, 1'b1, 3'd3, 32'd7, 32'd0, 2'b00, 2'b00, 32'd0);
        idle(DC + 1, 2'b00);
        step(1'b1, 1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2'b00, 32'd0);
        idle(DC, 2'b10);
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 2'b10, 2'b00, 32'h1234);
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 2'b01, 2'b10, 32'd0);
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 2'b10, 2'b01, 32'd10);
        step(1'b1, 1'b1, 3'd4, 32'd3, 32'd4, 2'b00, 2'b00, 32'd0);
        idle(MC - 1, 2'b00);
        step(1'b1, 1'b1, 3'd0, 32'd5, 32'd6, 2'b00, 2'b00, 32'd0);
        idle(MC + 1, 2'b01);
        step(1'b1, 1'b1, 3'd0, 32'd9, 32'd9, 2'b01, 2'b00, 32'h5555);
        idle(MC + 1, 2'b00);
        step(1'b1, 1'b1, 3'd2, 32'd100, 32'd7, 2'b00, 2'b00, 32'd0);
        idle(2, 2'b00);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 2'b00, 2'b01, 32'd0);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 2'b00, 2'b10, 32'd0);
        idle(DC + 2, 2'b10);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 399) != 0, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                 pick(), pick(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom());
        idle(2, 2'b00);
        @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
